// File: rtl/timer_ctrl_pkg.sv
// Shared encodings for the timer controller and the traffic-light FSM that drives it.
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        tbase      = 2'b00,
        textended  = 2'b01,
        tyellow    = 2'b10,
        tbasex2    = 2'b11
    } interval_e;

    typedef enum logic [1:0] {
        SEL_BASE = 2'b00,
        SEL_EXT  = 2'b01,
        SEL_YEL  = 2'b10,
        SEL_NONE = 2'b11
    } param_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [4:0] pick_duration(input interval_e iv, input logic [3:0] b,
                                                 input logic [3:0] e, input logic [3:0] y);
        logic [4:0] d;
        case (iv)
            tbase:     d = {1'b0, b};
            textended: d = {1'b0, e};
            tyellow:   d = {1'b0, y};
            tbasex2:   d = {b, 1'b0};
            default:   d = {1'b0, b};
        endcase
        return d;
    endfunction

    // A programmed value of zero means "go back to the default".
    function automatic logic [3:0] prog_value(input logic [3:0] v, input logic [3:0] def);
        return (v == 4'd0) ? def : v;
    endfunction

endpackage

// File: rtl/timer_ctrl_one_hz_divider.sv
// Prescaler: counts clk cycles while enabled and flags the last cycle of each second.
module one_hz_divider #(
    parameter int CLK_HZ = 100000000
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int CNT_W = $clog2(CLK_HZ);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt <= '0;
        end else if (clear || !enable || (r_cnt == L_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = enable && (r_cnt == L_LAST);

endmodule

// File: rtl/timer_ctrl.sv
// Programmable seconds countdown timer with one-cycle expiry pulse.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int CLK_HZ   = 100000000,
    parameter int DEF_BASE = 6,
    parameter int DEF_EXT  = 3,
    parameter int DEF_YEL  = 2
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       Reset_Sync,
    input  logic       Prog_Sync,
    input  logic [1:0] Time_Param_Sel,
    input  logic [3:0] Time_Value,
    input  logic [1:0] interval,
    input  logic       start_timer,
    output logic       expired,
    output logic [4:0] Time_Left,
    output logic       running
);
    localparam logic [3:0] L_DEF_BASE = 4'(DEF_BASE);
    localparam logic [3:0] L_DEF_EXT  = 4'(DEF_EXT);
    localparam logic [3:0] L_DEF_YEL  = 4'(DEF_YEL);

    state_e     r_state;
    logic [3:0] r_base, r_ext, r_yel;
    logic [4:0] r_time_left;
    logic       r_expired;
    logic       w_tick, w_clear, w_enable;
    logic [4:0] w_dur, w_dur_def;

    assign w_dur     = pick_duration(interval_e'(interval), r_base, r_ext, r_yel);
    assign w_dur_def = pick_duration(interval_e'(interval), L_DEF_BASE, L_DEF_EXT, L_DEF_YEL);
    assign w_clear   = start_timer || Reset_Sync;
    assign w_enable  = (r_state == RUN);

    one_hz_divider #(.CLK_HZ(CLK_HZ)) u_div (
        .clk     (clk),
        .Reset_n (Reset_n),
        .clear   (w_clear),
        .enable  (w_enable),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_base      <= L_DEF_BASE;
            r_ext       <= L_DEF_EXT;
            r_yel       <= L_DEF_YEL;
            r_time_left <= 5'd0;
            r_expired   <= 1'b0;
        end else begin
            r_expired <= 1'b0;
            if (Reset_Sync) begin
                r_base <= L_DEF_BASE;
                r_ext  <= L_DEF_EXT;
                r_yel  <= L_DEF_YEL;
                if (start_timer) begin
                    r_state     <= RUN;
                    r_time_left <= w_dur_def;
                end else begin
                    r_state     <= IDLE;
                    r_time_left <= 5'd0;
                end
            end else begin
                // Start samples w_dur from the current registers, so a coincident write lands after the load.
                if (Prog_Sync) begin
                    case (param_sel_e'(Time_Param_Sel))
                        SEL_BASE: r_base <= prog_value(Time_Value, L_DEF_BASE);
                        SEL_EXT:  r_ext  <= prog_value(Time_Value, L_DEF_EXT);
                        SEL_YEL:  r_yel  <= prog_value(Time_Value, L_DEF_YEL);
                        default:  ;
                    endcase
                end
                if (start_timer) begin
                    r_state     <= RUN;
                    r_time_left <= w_dur;
                end else if ((r_state == RUN) && w_tick) begin
                    if (r_time_left > 5'd1) begin
                        r_time_left <= r_time_left - 5'd1;
                    end else begin
                        r_time_left <= 5'd0;
                        r_state     <= IDLE;
                        r_expired   <= 1'b1;
                    end
                end
            end
        end
    end

    assign expired   = r_expired;
    assign Time_Left = r_time_left;
    assign running   = (r_state == RUN);

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomised scoreboard bench for timer_ctrl against a deadline-based reference model.
module tb_timer_ctrl;
    localparam int CLK = 4;
    localparam int DB  = 6;
    localparam int DE  = 3;
    localparam int DY  = 2;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Reset_Sync = 1'b0;
    logic       Prog_Sync = 1'b0;
    logic [1:0] Time_Param_Sel = 2'd0;
    logic [3:0] Time_Value = 4'd0;
    logic [1:0] interval = 2'd0;
    logic       start_timer = 1'b0;
    logic       expired;
    logic [4:0] Time_Left;
    logic       running;

    timer_ctrl #(.CLK_HZ(CLK), .DEF_BASE(DB), .DEF_EXT(DE), .DEF_YEL(DY)) dut (
        .clk            (clk),
        .Reset_n        (Reset_n),
        .Reset_Sync     (Reset_Sync),
        .Prog_Sync      (Prog_Sync),
        .Time_Param_Sel (Time_Param_Sel),
        .Time_Value     (Time_Value),
        .interval       (interval),
        .start_timer    (start_timer),
        .expired        (expired),
        .Time_Left      (Time_Left),
        .running        (running)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    // Reference model: a run is a start edge plus a duration; its deadline is start + N*CLK.
    int exp_q[$];
    bit m_run = 1'b0;
    int m_S = 0;
    int m_N = 0;
    int m_par[3] = '{DB, DE, DY};
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cyc=%0d", name, act, req, cyc);
        end
    endtask

    function automatic int dur(input int iv, input int b, input int e, input int y);
        case (iv)
            0:       return b;
            1:       return e;
            2:       return y;
            default: return 2 * b;
        endcase
    endfunction

    function automatic int defv(input int sel);
        case (sel)
            0:       return DB;
            1:       return DE;
            default: return DY;
        endcase
    endfunction

    task automatic launch(input int n);
        exp_q.delete();
        m_run = 1'b1;
        m_S   = cyc + 1;
        m_N   = n;
        exp_q.push_back(m_S + CLK * n);
    endtask

    task automatic step(input bit st, input int iv, input bit pg, input int sel,
                        input int val, input bit rs);
        @(negedge clk);
        #1;
        start_timer    = st;
        interval       = iv[1:0];
        Prog_Sync      = pg;
        Time_Param_Sel = sel[1:0];
        Time_Value     = val[3:0];
        Reset_Sync     = rs;
        if (rs) begin
            m_par = '{DB, DE, DY};
            if (st) launch(dur(iv, DB, DE, DY));
            else begin
                m_run = 1'b0;
                exp_q.delete();
            end
        end else begin
            if (st) launch(dur(iv, m_par[0], m_par[1], m_par[2]));
            if (pg && sel < 3) m_par[sel] = (val == 0) ? defv(sel) : val;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0, 0, 0, 1'b0);
    endtask

    always @(negedge clk) begin
        int j;
        int etl;
        int erun;
        if (mon_en) begin
            j = cyc - m_S;
            if (m_run && j < CLK * m_N) begin
                etl  = m_N - j / CLK;
                erun = 1;
            end else begin
                etl  = 0;
                erun = 0;
            end
            check("time_left", 32'(Time_Left), etl);
            check("running", 32'(running), erun);
            if (exp_q.size() > 0 && cyc == exp_q[0]) begin
                check("expired_due", 32'(expired), 1);
                void'(exp_q.pop_front());
            end else begin
                check("expired_quiet", 32'(expired), 0);
            end
        end
    end

    initial begin
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        #1 Reset_n = 1'b1;

        step(1, 2, 0, 0, 0, 0);           // tYEL: 2,1,0 over 8 cycles
        idle(10);

        step(0, 0, 1, 0, 9, 0);           // tBASE=9, then 2*tBASE
        step(1, 3, 0, 0, 0, 0);
        idle(75);

        step(1, 0, 0, 0, 0, 0);           // write during run leaves countdown alone
        idle(3);
        step(0, 0, 1, 0, 5, 0);
        idle(37);

        step(1, 0, 1, 0, 2, 0);           // coincident write: start uses old tBASE=5
        idle(22);

        step(1, 1, 0, 0, 0, 0);           // restart with tYEL 5 cycles in
        idle(4);
        step(1, 2, 0, 0, 0, 0);
        idle(12);

        step(0, 0, 1, 1, 7, 0);           // zero restores tEXT default
        step(0, 0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        idle(14);

        step(1, 2, 0, 0, 0, 0);           // restart on the expiring edge
        idle(7);
        step(1, 2, 0, 0, 0, 0);
        idle(10);

        step(1, 3, 0, 0, 0, 0);           // Reset_Sync aborts a run
        idle(5);
        step(0, 0, 0, 0, 0, 1);
        idle(5);

        step(0, 0, 1, 0, 9, 0);           // Reset_Sync + start from defaults, write ignored
        step(1, 3, 1, 1, 5, 1);
        idle(50);
        step(1, 1, 0, 0, 0, 0);
        idle(14);

        step(1, 1, 0, 0, 0, 0);           // asynchronous reset mid-run
        idle(5);
        @(negedge clk);
        #3 Reset_n = 1'b0;
        #1;
        check("async_time_left", 32'(Time_Left), 0);
        check("async_running", 32'(running), 0);
        check("async_expired", 32'(expired), 0);
        m_run = 1'b0;
        exp_q.delete();
        m_par = '{DB, DE, DY};
        repeat (2) @(negedge clk);
        #1 Reset_n = 1'b1;
        idle(20);

        for (int k = 0; k < 40; k++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 11) == 0));
            idle(int'($urandom_range(0, 25)));
        end

        idle(130);
        check("queue_drained", 32'(exp_q.size()), 0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
